// File: rtl/perf_counter_sequencer.sv
// Sequences start/stop/snapshot/clear requests from four requesters onto a
// shared performance-counter slave and returns per-section snapshots.
module perf_counter_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req_go,
  input  logic [3:0]  req_stop,
  input  logic [3:0]  req_snap,
  input  logic        clr_all,
  output logic [3:0]  avm_address,
  output logic        avm_write,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_id,
  output logic [63:0] res_time,
  output logic [31:0] res_events,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD_LO = 3'd2,
    S_RD_HI = 3'd3,
    S_RD_EV = 3'd4,
    S_CAP   = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  go_p_r, stop_p_r, snap_p_r;
  logic        clr_p_r;
  logic [3:0]  go_p_s, stop_p_s, snap_p_s;
  logic        clr_p_s;
  logic [3:0]  go_clr_s, stop_clr_s, snap_clr_s;
  logic        clr_clr_s;
  logic [1:0]  last_grant_r, last_grant_s;
  logic [1:0]  sel_s, idx_s;
  logic        sel_valid_s;
  logic [3:0]  any_p_s;
  logic [3:0]  addr_s;
  logic        write_s;
  logic [31:0] wdata_s;
  logic        res_valid_s;
  logic [1:0]  res_id_s;
  logic [63:0] res_time_s;
  logic [31:0] res_events_s;
  logic        busy_s;

  // Round-robin pick: the requester closest after last_grant wins.
  always_comb begin
    any_p_s     = go_p_r | stop_p_r | snap_p_r;
    sel_s       = 2'd0;
    sel_valid_s = 1'b0;
    idx_s       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx_s = last_grant_r + 2'(k) + 2'd1;
      if (any_p_s[idx_s]) begin
        sel_s       = idx_s;
        sel_valid_s = 1'b1;
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Next-state, next-output and pending-bit bookkeeping.
  always_comb begin
    state_s      = state_r;
    addr_s       = avm_address;
    write_s      = 1'b0;
    wdata_s      = 32'd0;
    res_valid_s  = res_valid;
    res_id_s     = res_id;
    res_time_s   = res_time;
    res_events_s = res_events;
    last_grant_s = last_grant_r;
    go_clr_s     = 4'd0;
    stop_clr_s   = 4'd0;
    snap_clr_s   = 4'd0;
    clr_clr_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (clr_p_r) begin
          state_s    = S_WR;
          addr_s     = 4'd0;
          write_s    = 1'b1;
          wdata_s    = 32'd1;
          clr_clr_s  = 1'b1;
          go_clr_s   = 4'hF;
          stop_clr_s = 4'hF;
        end else if (sel_valid_s) begin
          last_grant_s = sel_s;
          if (stop_p_r[sel_s]) begin
            state_s           = S_WR;
            addr_s            = {sel_s, 2'b00};
            write_s           = 1'b1;
            stop_clr_s[sel_s] = 1'b1;
          end else if (go_p_r[sel_s]) begin
            state_s         = S_WR;
            addr_s          = {sel_s, 2'b01};
            write_s         = 1'b1;
            go_clr_s[sel_s] = 1'b1;
          end else begin
            state_s           = S_RD_LO;
            addr_s            = {sel_s, 2'b00};
            res_id_s          = sel_s;
            snap_clr_s[sel_s] = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR:    state_s = S_IDLE;
      S_RD_LO: begin
        state_s = S_RD_HI;
        addr_s  = {res_id, 2'b01};
      end
      // Slave read data lags the address by one cycle.
      S_RD_HI: begin
        state_s          = S_RD_EV;
        addr_s           = {res_id, 2'b10};
        res_time_s[31:0] = avm_readdata;
      end
      S_RD_EV: begin
        state_s           = S_CAP;
        res_time_s[63:32] = avm_readdata;
      end
      S_CAP: begin
        state_s      = S_RESP;
        res_events_s = avm_readdata;
        res_valid_s  = 1'b1;
      end
      S_RESP: begin
        if (res_ready) begin
          state_s     = S_IDLE;
          res_valid_s = 1'b0;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s     = S_IDLE;
        res_valid_s = 1'b0;
      end
    endcase

    // A pulse coinciding with its own clear stays pending.
    go_p_s   = (go_p_r & ~go_clr_s) | req_go;
    stop_p_s = (stop_p_r & ~stop_clr_s) | req_stop;
    snap_p_s = (snap_p_r & ~snap_clr_s) | req_snap;
    clr_p_s  = (clr_p_r & ~clr_clr_s) | clr_all;
    busy_s   = (state_s != S_IDLE) || (|go_p_s) || (|stop_p_s) || (|snap_p_s) || clr_p_s;
  end

  // State, pending bits and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= S_IDLE;
      go_p_r            <= 4'd0;
      stop_p_r          <= 4'd0;
      snap_p_r          <= 4'd0;
      clr_p_r           <= 1'b0;
      last_grant_r      <= 2'd3;
      avm_address       <= 4'd0;
      avm_write         <= 1'b0;
      avm_begintransfer <= 1'b0;
      avm_writedata     <= 32'd0;
      res_valid         <= 1'b0;
      res_id            <= 2'd0;
      res_time          <= 64'd0;
      res_events        <= 32'd0;
      busy              <= 1'b0;
    end else begin
      state_r           <= state_s;
      go_p_r            <= go_p_s;
      stop_p_r          <= stop_p_s;
      snap_p_r          <= snap_p_s;
      clr_p_r           <= clr_p_s;
      last_grant_r      <= last_grant_s;
      avm_address       <= addr_s;
      avm_write         <= write_s;
      avm_begintransfer <= write_s;
      avm_writedata     <= wdata_s;
      res_valid         <= res_valid_s;
      res_id            <= res_id_s;
      res_time          <= res_time_s;
      res_events        <= res_events_s;
      busy              <= busy_s;
    end
  end

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench for perf_counter_sequencer with a behavioural counter slave.
module tb_perf_counter_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_go, req_stop, req_snap;
  logic        clr_all;
  logic [3:0]  avm_address;
  logic        avm_write, avm_begintransfer;
  logic [31:0] avm_writedata, avm_readdata;
  logic        res_valid, res_ready;
  logic [1:0]  res_id;
  logic [63:0] res_time;
  logic [31:0] res_events;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0]  wq[$];
  logic [1:0]   rq_id[$];
  logic [31:0]  rq_ev[$];
  logic [63:0]  rq_lo[$];
  logic [63:0]  rq_hi[$];

  perf_counter_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_go(req_go), .req_stop(req_stop), .req_snap(req_snap), .clr_all(clr_all),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_begintransfer(avm_begintransfer), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_time(res_time), .res_events(res_events), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter slave: per section, word 0 stop / time lo, word 1 go / time hi, word 2 events.
  logic [63:0] t_c [4];
  logic [31:0] e_c [4];
  logic [3:0]  run;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        t_c[i] <= 64'd0;
        e_c[i] <= 32'd0;
      end
      run          <= 4'd0;
      avm_readdata <= 32'd0;
    end else begin
      case (avm_address[1:0])
        2'd0:    avm_readdata <= t_c[avm_address[3:2]][31:0];
        2'd1:    avm_readdata <= t_c[avm_address[3:2]][63:32];
        2'd2:    avm_readdata <= e_c[avm_address[3:2]];
        default: avm_readdata <= 32'd0;
      endcase
      for (int i = 0; i < 4; i++)
        if (run[i]) t_c[i] <= t_c[i] + 64'd1;
      if (avm_write) begin
        if (avm_address == 4'd0 && avm_writedata == 32'd1) begin
          for (int i = 0; i < 4; i++) begin
            t_c[i] <= 64'd0;
            e_c[i] <= 32'd0;
          end
          run <= 4'd0;
        end else if (avm_address[1:0] == 2'd0) begin
          run[avm_address[3:2]] <= 1'b0;
        end else if (avm_address[1:0] == 2'd1) begin
          run[avm_address[3:2]] <= 1'b1;
          e_c[avm_address[3:2]] <= e_c[avm_address[3:2]] + 32'd1;
        end
      end
    end
  end

  // Scoreboard monitor: pops expected writes and results as the DUT produces them.
  always @(negedge clk) begin
    logic [35:0] ew;
    if (reset_n) begin
      if (avm_write) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got addr %0d data %0h, want no write", avm_address, avm_writedata);
        end else begin
          ew = wq.pop_front();
          if ({avm_address, avm_writedata} !== ew || avm_begintransfer !== 1'b1) begin
            n_err++;
            $display("FAIL wr_data: got addr %0d data %0h bt %0b, want addr %0d data %0h bt 1",
                     avm_address, avm_writedata, avm_begintransfer, ew[35:32], ew[31:0]);
          end
        end
      end else begin
        n_cmp++;
        if (avm_begintransfer !== 1'b0 || avm_writedata !== 32'd0) begin
          n_err++;
          $display("FAIL idle_bus: got bt %0b data %0h, want bt 0 data 0", avm_begintransfer, avm_writedata);
        end
      end
      if (res_valid && res_ready) begin
        n_cmp++;
        if (rq_id.size() == 0) begin
          n_err++;
          $display("FAIL res_unexpected: got id %0d, want no result", res_id);
        end else begin
          logic [1:0]  eid;
          logic [31:0] eev;
          logic [63:0] elo, ehi;
          eid = rq_id.pop_front();
          eev = rq_ev.pop_front();
          elo = rq_lo.pop_front();
          ehi = rq_hi.pop_front();
          if (res_id !== eid || res_events !== eev || res_time < elo || res_time > ehi) begin
            n_err++;
            $display("FAIL res_data: got id %0d time %0d ev %0d, want id %0d time %0d..%0d ev %0d",
                     res_id, res_time, res_events, eid, elo, ehi, eev);
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
    wq.push_back({a, d});
  endtask

  task automatic push_res(input logic [1:0] id, input logic [31:0] ev, input logic [63:0] lo, input logic [63:0] hi);
    rq_id.push_back(id);
    rq_ev.push_back(ev);
    rq_lo.push_back(lo);
    rq_hi.push_back(hi);
  endtask

  task automatic pulse(input logic [3:0] go, input logic [3:0] stop, input logic [3:0] snap, input logic clr);
    @(posedge clk); #1;
    req_go = go; req_stop = stop; req_snap = snap; clr_all = clr;
    @(posedge clk); #1;
    req_go = 4'd0; req_stop = 4'd0; req_snap = 4'd0; clr_all = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < 400);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_timeout: got busy %0b, want 0", name, busy);
    end
    n_cmp++;
    if (wq.size() != 0 || rq_id.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d writes %0d results left, want 0 0", name, wq.size(), rq_id.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({avm_address, avm_write, avm_begintransfer, avm_writedata, res_valid, res_id,
         res_time, res_events, busy} !== 110'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr %0d wr %0b val %0b time %0d ev %0d busy %0b, want all 0",
               avm_address, avm_write, res_valid, res_time, res_events, busy);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_go();
    push_wr(4'd9, 32'd0);
    pulse(4'b0100, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (avm_write !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL go_t1: got wr %0b busy %0b, want wr 0 busy 1", avm_write, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (avm_write !== 1'b1 || busy !== 1'b1 || avm_address !== 4'd9) begin
      n_err++;
      $display("FAIL go_t2: got wr %0b busy %0b addr %0d, want wr 1 busy 1 addr 9", avm_write, busy, avm_address);
    end
    @(negedge clk);
    n_cmp++;
    if (avm_write !== 1'b0 || busy !== 1'b0 || avm_address !== 4'd9) begin
      n_err++;
      $display("FAIL go_t3: got wr %0b busy %0b addr %0d, want wr 0 busy 0 addr 9", avm_write, busy, avm_address);
    end
    wait_idle("single_go");
  endtask

  task automatic test_stop_go_same();
    push_wr(4'd4, 32'd0);
    push_wr(4'd5, 32'd0);
    pulse(4'b0010, 4'b0010, 4'd0, 1'b0);
    wait_idle("stop_go");
  endtask

  task automatic test_round_robin();
    do_reset();
    push_wr(4'd1, 32'd0);
    push_wr(4'd5, 32'd0);
    push_wr(4'd9, 32'd0);
    push_wr(4'd13, 32'd0);
    pulse(4'hF, 4'd0, 4'd0, 1'b0);
    wait_idle("round_robin");
  endtask

  task automatic test_snapshot();
    int cnt;
    do_reset();
    push_wr(4'd1, 32'd0);
    pulse(4'b0001, 4'd0, 4'd0, 1'b0);
    repeat (98) @(posedge clk);
    push_wr(4'd0, 32'd0);
    pulse(4'd0, 4'b0001, 4'd0, 1'b0);
    wait_idle("snap_setup");
    res_ready = 1'b0;
    push_res(2'd0, 32'd1, 64'd100, 64'd104);
    pulse(4'd0, 4'd0, 4'b0001, 1'b0);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (res_valid) break;
    end
    n_cmp++;
    if (cnt != 6) begin
      n_err++;
      $display("FAIL snap_latency: got %0d cycles, want 6", cnt);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_id !== 2'd0 || res_events !== 32'd1 ||
          res_time < 64'd100 || res_time > 64'd104) begin
        n_err++;
        $display("FAIL snap_hold: got val %0b id %0d time %0d ev %0d, want val 1 id 0 time 100..104 ev 1",
                 res_valid, res_id, res_time, res_events);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL snap_release: got val %0b, want 0", res_valid);
    end
    wait_idle("snapshot");
  endtask

  task automatic test_clear();
    do_reset();
    push_wr(4'd5, 32'd0);
    pulse(4'b0010, 4'd0, 4'd0, 1'b0);
    repeat (20) @(posedge clk);
    push_wr(4'd0, 32'd1);
    push_res(2'd1, 32'd0, 64'd0, 64'd0);
    pulse(4'b1000, 4'd0, 4'b0010, 1'b1);
    wait_idle("clear");
  endtask

  task automatic test_reset_abort();
    pulse(4'd0, 4'd0, 4'b0100, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({avm_address, avm_write, avm_begintransfer, avm_writedata, res_valid, res_id,
         res_time, res_events, busy} !== 110'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got addr %0d wr %0b val %0b id %0d busy %0b, want all 0",
               avm_address, avm_write, res_valid, res_id, busy);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0 || avm_write !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet: got val %0b wr %0b busy %0b, want 0 0 0", res_valid, avm_write, busy);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_go    = 4'd0;
    req_stop  = 4'd0;
    req_snap  = 4'd0;
    clr_all   = 1'b0;
    res_ready = 1'b1;
    test_reset();
    test_single_go();
    test_stop_go_same();
    test_round_robin();
    test_snapshot();
    test_clear();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
